// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple-borrow subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
module serial_borrow_subtractor #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             a_bit, b_bit, d_bit, borrow_nx;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs and the registered borrow
  always_comb begin
    a_bit     = a_sh_q[0];
    b_bit     = b_sh_q[0];
    d_bit     = a_bit ^ b_bit ^ borrow_q;
    borrow_nx = (~a_bit & b_bit) | (~a_bit & borrow_q) | (b_bit & borrow_q);
    res_shift = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
  end

  // Next-state and output-register logic
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sh_d   = a_i;
          b_sh_d   = b_i;
          res_d    = '0;
          borrow_d = bin_i;
          cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d  = a_i[WIDTH-1];
          b_msb_d  = b_i[WIDTH-1];
`endif
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_shift;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish the full result only on completion, never partial bits
          diff_d  = res_shift;
          bout_d  = borrow_nx;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Self-checking bench for serial_borrow_subtractor (WIDTH=3 and WIDTH=8 instances).
// Builds with or without SERIAL_SUB_OVF_EN.
module tb_serial_borrow_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start, bin, busy, done, bout;
  logic [2:0] a, b, diff;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf, ovf8;
`endif

  int checks = 0;
  int passes = 0;

  serial_borrow_subtractor #(.WIDTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .bin_i(bin),
    .busy_o(busy), .done_o(done), .diff_o(diff), .bout_o(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf_o(ovf)
`endif
  );

  serial_borrow_subtractor #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf_o(ovf8)
`endif
  );

  // Reference: {BOUT,DIFF} is the (w+1)-bit two's-complement image of a-b-bin
  function automatic logic [8:0] ref_sub(input int av, input int bv, input int binv, input int w);
    int r;
    r = av - bv - binv;
    return 9'(r & ((1 << (w + 1)) - 1));
  endfunction

  // Reference: signed overflow of the w-bit signed difference
  function automatic logic ref_ovf(input int av, input int bv, input int binv, input int w);
    int sa, sb, r;
    sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r  = sa - sb - binv;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  // Drives one WIDTH=3 op and observes it; lat stays -1 if DONE never arrives
  task automatic do_op(input logic [2:0] av, input logic [2:0] bv, input logic binv,
                       output int lat, output int nbusy, output int ndone,
                       output logic [2:0] d, output logic bo, output logic ov);
    @(negedge clk);
    a = av; b = bv; bin = binv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; nbusy = 0; ndone = 0; d = 'x; bo = 1'bx; ov = 1'bx;
    for (int i = 0; i < 7; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = i; d = diff; bo = bout;
`ifdef SERIAL_SUB_OVF_EN
          ov = ovf;
`else
          ov = 1'b0;
`endif
        end
      end
      a = 3'($urandom); b = 3'($urandom); bin = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; bin = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    #2;
    checks++; if ({busy, done, bout, diff} !== 6'b0) $display("FAIL reset3 got %b want 000000", {busy, done, bout, diff}); else passes++;
    checks++; if ({busy8, done8, bout8, diff8} !== 11'b0) $display("FAIL reset8 got %b want 0", {busy8, done8, bout8, diff8}); else passes++;
`ifdef SERIAL_SUB_OVF_EN
    checks++; if ({ovf, ovf8} !== 2'b00) $display("FAIL reset_ovf got %b want 00", {ovf, ovf8}); else passes++;
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat, nb, nd; logic [2:0] d; logic bo, ov;
    do_op(3'd5, 3'd3, 1'b0, lat, nb, nd, d, bo, ov);
    checks++; if (lat !== 3) $display("FAIL lat_5_3 got %0d want 3", lat); else passes++;
    checks++; if (nb !== 3) $display("FAIL busy_5_3 got %0d want 3", nb); else passes++;
    checks++; if (nd !== 1) $display("FAIL done_5_3 got %0d want 1", nd); else passes++;
    checks++; if ({bo, d} !== 4'b0_010) $display("FAIL res_5_3 got %b want 0010", {bo, d}); else passes++;
    do_op(3'd2, 3'd5, 1'b0, lat, nb, nd, d, bo, ov);
    checks++; if ({bo, d} !== 4'b1_101) $display("FAIL res_2_5 got %b want 1101", {bo, d}); else passes++;
    do_op(3'd0, 3'd0, 1'b1, lat, nb, nd, d, bo, ov);
    checks++; if ({bo, d} !== 4'b1_111) $display("FAIL res_0_0_1 got %b want 1111", {bo, d}); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 3'd3; b = 3'd2; bin = 1'b0; start = 1'b1;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      a = 3'($urandom); b = 3'($urandom); bin = 1'($urandom);
    end
    checks++; if (lat !== 3) $display("FAIL b2b_lat1 got %0d want 3", lat); else passes++;
    checks++; if ({bout, diff} !== 4'b0_001) $display("FAIL b2b_res1 got %b want 0001", {bout, diff}); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_in_done got %b want 0", busy); else passes++;
    a = 3'd6; b = 3'd1; bin = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = i; break; end
      a = 3'($urandom); b = 3'($urandom); bin = 1'($urandom);
    end
    checks++; if (lat !== 3) $display("FAIL b2b_lat2 got %0d want 3", lat); else passes++;
    checks++; if ({bout, diff} !== 4'b0_101) $display("FAIL b2b_res2 got %b want 0101", {bout, diff}); else passes++;
  endtask

  task automatic test_reset_abort();
    int lat, nb, nd; logic [2:0] d; logic bo, ov;
    @(negedge clk);
    a = 3'd7; b = 3'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, bout, diff} !== 6'b0) $display("FAIL abort_clear got %b want 000000", {busy, done, bout, diff}); else passes++;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++; if (nd !== 0) $display("FAIL abort_nodone got %0d want 0", nd); else passes++;
    do_op(3'd4, 3'd4, 1'b0, lat, nb, nd, d, bo, ov);
    checks++; if ({bo, d} !== 4'b0_000) $display("FAIL post_abort got %b want 0000", {bo, d}); else passes++;
    checks++; if (lat !== 3) $display("FAIL post_abort_lat got %0d want 3", lat); else passes++;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat, nb, nd; logic [2:0] d; logic bo, ov;
    do_op(3'd3, 3'd7, 1'b0, lat, nb, nd, d, bo, ov);
    checks++; if ({ov, bo, d} !== 5'b1_1_100) $display("FAIL ovf_3_7 got %b want 11100", {ov, bo, d}); else passes++;
    do_op(3'd3, 3'd1, 1'b0, lat, nb, nd, d, bo, ov);
    checks++; if ({ov, bo, d} !== 5'b0_0_010) $display("FAIL ovf_3_1 got %b want 00010", {ov, bo, d}); else passes++;
  endtask
`endif

  task automatic test_sweep3();
    int lat, nb, nd; logic [2:0] d; logic bo, ov; logic [3:0] exp;
    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          do_op(3'(ia), 3'(ib), 1'(ic), lat, nb, nd, d, bo, ov);
          exp = 4'(ref_sub(ia, ib, ic, 3));
          checks++; if ({bo, d} !== exp) $display("FAIL sweep3 a=%0d b=%0d bin=%0d got %b want %b", ia, ib, ic, {bo, d}, exp); else passes++;
          checks++; if (nd !== 1 || lat !== 3) $display("FAIL sweep3_done a=%0d b=%0d dones=%0d lat=%0d want 1/3", ia, ib, nd, lat); else passes++;
`ifdef SERIAL_SUB_OVF_EN
          checks++; if (ov !== ref_ovf(ia, ib, ic, 3)) $display("FAIL sweep3_ovf a=%0d b=%0d bin=%0d got %b", ia, ib, ic, ov); else passes++;
`endif
        end
  endtask

  task automatic test_width8();
    int av, bv, cv, lat, nd; logic [8:0] got, exp;
    for (int n = 0; n < 30; n++) begin
      av = int'($urandom_range(0, 255)); bv = int'($urandom_range(0, 255)); cv = int'($urandom_range(0, 1));
      @(negedge clk);
      a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(cv); start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      lat = -1; nd = 0; got = 'x;
      for (int i = 0; i < 12; i++) begin
        if (done8) begin
          nd++;
          if (lat < 0) begin lat = i; got = {bout8, diff8}; end
        end
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        @(negedge clk);
      end
      exp = ref_sub(av, bv, cv, 8);
      checks++; if (got !== exp) $display("FAIL w8 a=%0d b=%0d bin=%0d got %h want %h", av, bv, cv, got, exp); else passes++;
      checks++; if (nd !== 1 || lat !== 8) $display("FAIL w8_done dones=%0d lat=%0d want 1/8", nd, lat); else passes++;
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf8 !== ref_ovf(av, bv, cv, 8)) $display("FAIL w8_ovf a=%0d b=%0d got %b", av, bv, ovf8); else passes++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_sweep3();
    test_width8();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
# serial_borrow_subtractor

Bit-serial ripple-borrow subtractor: computes DIFF = A − B − BIN over WIDTH bits, processing one bit per clock from LSB to MSB through a single registered borrow stage. It is the subtract-direction counterpart of the combinational ripple carry adder in the arithmetic datapath. It trades WIDTH cycles of latency for one full-subtractor cell. Operands are accepted with a START/BUSY/DONE handshake.

## Interface

- WIDTH, 3, operand and result width in bits; must be ≥ 1.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request to begin an operation; sampled only while idle.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- BIN  input  1  borrow-in; captured on the accepting edge.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when DIFF/BOUT are updated.
- DIFF  output  WIDTH  registered result A − B − BIN (mod 2^WIDTH).
- BOUT  output  1  registered borrow-out from the MSB stage.
- OVF  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation

- FSM states: IDLE, RUN.
- IDLE: when START=1, capture A and B into shift registers, set borrow register ← BIN, set bit counter ← 0, and go to RUN. When START=0, stay in IDLE.
- RUN: every cycle, take a = A_sh[0], b = B_sh[0], c = borrow, and:
  - d = a ^ b ^ c
  - borrow ← (~a & b) | (~a & c) | (b & c)
  - shift d into the MSB of the result shift register
  - shift A_sh and B_sh right by one
  - counter ← counter + 1
- When the counter reaches WIDTH−1 in RUN, on that edge:
  - DIFF ← final result shift-register contents, including that cycle's d
  - BOUT ← that cycle's borrow_next
  - DONE ← 1
  - state ← IDLE
- DIFF, BOUT and OVF are separate output registers. They hold the last completed result and never show partial values. They change only on a completion edge.
- START while BUSY=1 is ignored; no queuing.
- Arithmetic is unsigned modulo 2^WIDTH. BOUT=1 exactly when {A} < {B} + BIN.
- The counter is $clog2(WIDTH+1) bits wide. WIDTH=1 completes in a single RUN cycle.

## Timing

- Reset (asynchronous assert): state=IDLE, BUSY=0, DONE=0, DIFF=0, BOUT=0, OVF=0, and internal shift registers, borrow and counter cleared.
- Reset deassertion is synchronized externally; the block needs no internal synchronizer.
- Let edge k be the edge that accepts START. BUSY is high after edges k … k+WIDTH−1. Bits are processed on edges k+1 … k+WIDTH.
- DONE is high for exactly one cycle, after edge k+WIDTH. DIFF/BOUT are valid from that cycle on. Latency is WIDTH cycles from the accepting edge.
- In the DONE cycle the FSM is already IDLE and BUSY=0, so a START then is accepted. Back-to-back throughput is one operation per WIDTH+1 cycles... (more precisely, a new operation may be accepted on the edge ending the DONE cycle).
- Reset during RUN aborts the operation: no DONE pulse, and outputs are cleared.
- Inputs A/B/BIN are don't-care except on the accepting edge.

## Configuration

- SERIAL_SUB_OVF_EN defined:
  - The OVF port exists.
  - On the completion edge, OVF ← (A[MSB] ≠ B[MSB]) & (DIFF[MSB] ≠ A[MSB]), using the captured A/B MSBs (registered at accept) and the final d.
  - OVF is held with DIFF.
- SERIAL_SUB_OVF_EN not defined:
  - No OVF port and no MSB capture registers.
  - All other behaviour is identical.

## Test plan

- WIDTH=3, A=5, B=3, BIN=0, START one cycle → BUSY for 3 cycles; DONE pulse 3 cycles after the accepting edge; DIFF=2, BOUT=0.
- A=2, B=5, BIN=0 → DIFF=5 (−3 mod 8), BOUT=1. A=0, B=0, BIN=1 → DIFF=7, BOUT=1.
- START held high and A/B changed during RUN → result reflects only the first captured operands. A second START asserted in the DONE cycle with A=6, B=1 → new result DIFF=5, BOUT=0 one operation later.
- Assert RST after the second RUN cycle of A=7, B=1 → outputs go 0 immediately, and no DONE. After release, A=4, B=4 → DIFF=0, BOUT=0.
- SERIAL_SUB_OVF_EN defined: A=3, B=7 → DIFF=4, BOUT=1, OVF=1. A=3, B=1 → DIFF=2, OVF=0.
- Random sweep of all A, B, BIN for WIDTH=3, plus a sample for WIDTH=8 → {BOUT,DIFF} equals the two's-complement (WIDTH+1)-bit value of A−B−BIN, DONE exactly once per op.
